// File: rtl/mst_fifo_pkg.sv
// Shared types and helpers for the FT600 master FIFO streaming test.
// Used by the packet generator and the loopback data checker.
package mst_fifo_pkg;

  localparam int NCH_DEF = 4;
  localparam int CHN_W   = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP
  } state_t;

  // Valid bytes in a final word to byte enables; 0 means a full word.
  function automatic logic [3:0] tail_be(input logic [1:0] t);
    logic [3:0] be;
    unique case (t)
      2'd1:    be = 4'h1;
      2'd2:    be = 4'h3;
      2'd3:    be = 4'h7;
      default: be = 4'hF;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/mst_vr_reg.sv
// Valid/ready output holding register for the packet generator.
// Payload stays frozen while valid is high and the consumer stalls.
module mst_vr_reg
  import mst_fifo_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_ld,
  input  logic [31:0]      i_data,
  input  logic [3:0]       i_be,
  input  logic [CHN_W-1:0] i_chn,
  input  logic             i_last,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [31:0]      o_data,
  output logic [3:0]       o_be,
  output logic [CHN_W-1:0] o_chn,
  output logic             o_last
);

  // Capture a new word on load, drop valid once the word is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_be    <= '0;
      o_chn   <= '0;
      o_last  <= 1'b0;
    end else if (i_ld) begin
      o_valid <= 1'b1;
      o_data  <= i_data;
      o_be    <= i_be;
      o_chn   <= i_chn;
      o_last  <= i_last;
    end else if (o_valid && i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mst_pkt_gen.sv
// Packetised incrementing-data source for the FT600 streaming test.
// Round-robins channels between packets, trims BE on the last word.
module mst_pkt_gen
  import mst_fifo_pkg::*;
#(
  parameter int NCH   = NCH_DEF,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             mltcn,
  input  logic [LEN_W-1:0] pkt_len,
  input  logic [1:0]       tail_bytes,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [3:0]       out_be,
  output logic [CHN_W-1:0] out_chn,
  output logic             out_last,
  output logic             pkt_done,
  output logic             busy
);

  state_t                r_state;
  logic [LEN_W-1:0]      r_rem;
  logic [1:0]            r_tail;
  logic [CHN_W-1:0]      r_chn;
  logic [NCH-1:0][31:0]  r_cnt;
  logic                  r_done;

  logic                  w_clr;
  logic                  w_acc;
  logic                  w_free;
  logic                  w_start;
  logic [CHN_W-1:0]      w_nxt_chn;
  logic                  w_ld;
  logic [CHN_W-1:0]      w_ld_chn;
  logic                  w_ld_last;
  logic [1:0]            w_ld_tail;
  logic [31:0]           w_ld_data;
  logic [3:0]            w_ld_be;

  assign w_clr   = rst | clr;
  assign w_acc   = out_valid & out_ready;
  assign w_free  = ~out_valid | out_ready;
  assign w_start = en && (pkt_len != '0);

  assign busy     = (r_state != ST_IDLE);
  assign pkt_done = r_done;

  // Channel for the next packet; 245 mode pins channel 0.
  always_comb begin
    w_nxt_chn = '0;
    if (mltcn && (r_chn != CHN_W'(NCH - 1)))
      w_nxt_chn = r_chn + 1'b1;
  end

  // Next-word selection; GAP loads the next packet's first word
  // directly so only one bubble separates packets.
  always_comb begin
    w_ld      = 1'b0;
    w_ld_chn  = r_chn;
    w_ld_last = (r_rem == LEN_W'(1));
    w_ld_tail = r_tail;
    unique case (r_state)
      ST_SEND: w_ld = w_free && (r_rem != '0);
      ST_GAP: begin
        if (w_start) begin
          w_ld      = w_free;
          w_ld_chn  = w_nxt_chn;
          w_ld_last = (pkt_len == LEN_W'(1));
          w_ld_tail = tail_bytes;
        end
      end
      default: ;
    endcase
    w_ld_data = r_cnt[w_ld_chn];
    w_ld_be   = w_ld_last ? tail_be(w_ld_tail) : 4'hF;
  end

  // Packet FSM, remaining-word count, channel pointer and counters.
  // A counter steps when its word is loaded; every loaded word is
  // accepted unless a clear intervenes, which zeroes it anyway.
  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_state <= ST_IDLE;
      r_rem   <= '0;
      r_tail  <= '0;
      r_chn   <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_acc && out_last;
      if (w_ld)
        r_cnt[w_ld_chn] <= r_cnt[w_ld_chn] + 32'd1;
      unique case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_rem   <= pkt_len;
            r_tail  <= tail_bytes;
            r_state <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (w_ld)
            r_rem <= r_rem - 1'b1;
          if (w_acc && out_last)
            r_state <= ST_GAP;
        end
        ST_GAP: begin
          r_chn <= w_nxt_chn;
          if (w_start) begin
            r_rem   <= pkt_len - 1'b1;
            r_tail  <= tail_bytes;
            r_state <= ST_SEND;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  mst_vr_reg u_oreg (
    .clk     (clk),
    .rst     (w_clr),
    .i_ld    (w_ld),
    .i_data  (w_ld_data),
    .i_be    (w_ld_be),
    .i_chn   (w_ld_chn),
    .i_last  (w_ld_last),
    .i_ready (out_ready),
    .o_valid (out_valid),
    .o_data  (out_data),
    .o_be    (out_be),
    .o_chn   (out_chn),
    .o_last  (out_last)
  );

endmodule

// File: doc/mst_pkt_gen.md
# mst_pkt_gen

Packetised streaming source for the FT600 master FIFO streaming test. It generates per-channel incrementing 32-bit data in packets of programmable length with byte-enable trimming on the final word. It feeds the pre-fetch stage through a valid/ready handshake, rotating round-robin over channels in multi-channel mode. It sits directly upstream of the pre-fetch / internal-FIFO read path and supplies the words the loopback checker expects.

## Interface
- `NCH`, default 4: number of channels; channel index width is 2.
- `LEN_W`, default 16: width of the packet-length field.
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `clr` in 1: synchronous soft clear, driven from the read out-of-band strobe; identical effect to `rst`.
- `en` in 1: run enable; sampled at packet boundaries only.
- `mltcn` in 1: 1 = rotate channels 0..NCH-1; 0 = 245 mode, channel 0 only.
- `pkt_len` in LEN_W: words per packet; 0 = do not start.
- `tail_bytes` in 2: valid bytes in the last word; 0 means all 4.
- `out_valid` out 1: word available.
- `out_ready` in 1: consumer accepts.
- `out_data` out 32: payload.
- `out_be` out 4: byte enables.
- `out_chn` out 2: channel of the current word.
- `out_last` out 1: final word of the packet.
- `pkt_done` out 1: one-cycle pulse when a last word is accepted.
- `busy` out 1: high in any state other than IDLE.

## Operation
- Each channel has a 32-bit sequence counter, reset to 0, that increments by 1 on each accepted word of that channel. It wraps from 0xFFFFFFFF to 0. `out_data` is the current counter value of the selected channel.
- FSM states: IDLE, SEND, GAP.
  - IDLE: if `en` and `pkt_len` != 0, latch `pkt_len` into `rem` and `tail_bytes` into `tail`, then go to SEND.
  - SEND: load or advance the output register. When the word with `rem`==1 is accepted, go to GAP.
  - GAP: advance the channel pointer (if `mltcn`, (chn+1) mod NCH; otherwise stays 0). Then, if `en` and `pkt_len` != 0, re-latch and go to SEND; otherwise go to IDLE.
- Output register load rule: load when (`!out_valid` || `out_ready`) and a word remains. `out_last` = (`rem`==1).
- `out_be` is 4'hF, except on the last word when `tail` is 1, 2 or 3, giving 4'h1, 4'h3 or 4'h7 respectively.
- Deasserting `en` mid-packet does not truncate: the packet completes and the FSM then returns to IDLE. `pkt_len` and `tail_bytes` changes mid-packet are ignored.
- `mltcn` is sampled only in GAP. A change mid-packet takes effect at the next boundary.
- Reset/clear values: `out_valid`=0, `out_data`=0, `out_be`=0, `out_chn`=0, `out_last`=0, `pkt_done`=0, `busy`=0, state IDLE, all counters and `rem` = 0, channel pointer = 0.
- `rst` or `clr` mid-packet abandons the packet immediately. `clr` has priority over `en` in the same cycle.

## Timing
- `en` sampled high at edge k in IDLE: first `out_valid` is visible after edge k+1 (2-cycle start latency).
- With `out_ready` held high: one word per cycle, no bubbles within a packet. Exactly one bubble cycle (GAP) between packets.
- `out_valid`=1 with `out_ready`=0: `out_data`, `out_be`, `out_chn` and `out_last` stay stable. `out_valid` never drops without acceptance, except on `rst`/`clr`.
- `pkt_done` asserts in the cycle after the last word is accepted, for exactly 1 cycle.
- `pkt_len`=1: a single word with `out_last`=1 and trimmed `out_be`.
- `pkt_len` = 2^LEN_W−1 is supported. `rem` never underflows.

## Structure
- Shared package `mst_fifo_pkg` holds:
  - the channel-count constant and channel-index width;
  - the FSM state enum;
  - the tail-bytes-to-BE decode function, which is reused by the data checker.
- One sub-module, `mst_vr_reg`: the valid/ready output holding register (payload, BE, channel, last). The FSM, channel pointer and sequence counters stay in the top.

## Test plan
- `mltcn`=0, `pkt_len`=4, `tail_bytes`=0, `out_ready`=1, `en` pulsed for one cycle: expect words 0,1,2,3 on channel 0, `out_be`=F on all four, `out_last` on word 3, one `pkt_done`, then IDLE.
- `mltcn`=1, `pkt_len`=2, `en` held: expect channel order 0,1,2,3,0 and data 0,1 per channel, then 2,3 on the second visit to channel 0, with one bubble between packets.
- `out_ready` toggled randomly, `pkt_len`=8: expect outputs stable while stalled, no loss or duplication, and the sequence 0..7 intact.
- `tail_bytes`=1/2/3 with `pkt_len`=1: expect `out_be`=1/3/7 respectively, with `out_last`=1.
- Counter preset near wrap via 2^32−2 accepted words (forced): expect FFFFFFFE, FFFFFFFF, 00000000.
- `clr` asserted mid-packet while stalled: next cycle `out_valid`=0, `busy`=0, all counters 0. With `en` high, the restarted packet begins at data 0 on channel 0.
